// File: rtl/quiz_score_tracker.sv
// Fixed-length quiz scoring engine: awards POINTS per correct answer, times out idle questions.
// Latency: score/round update on the edge sampling the resolving event; pulses visible next cycle.
// Backpressure: none; start/ans_valid are single-cycle pulses that are always accepted or ignored.
module quiz_score_tracker #(
    parameter int NUM_ROUNDS     = 10,
    parameter int POINTS         = 10,
    parameter int MAX_SCORE      = 100,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TO_W           = 26
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    input  logic       ans_valid,
    input  logic       ans_correct,
    output logic [6:0] score,
    output logic [3:0] round,
    output logic       busy,
    output logic       done,
    output logic       score_upd,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0]      PTS8       = 8'(POINTS);
    localparam logic [6:0]      MAX7       = 7'(MAX_SCORE);
    localparam logic [3:0]      LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE     = TO_W'(1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [6:0]      score_d;
    logic [3:0]      round_d;
    logic            upd_d, to_d;
    logic [7:0]      sum8;
    logic [6:0]      add_score;

    // Add at 8 bits so the carry past 127 is visible before clamping.
    assign sum8      = {1'b0, score} + PTS8;
    assign add_score = (sum8 > {1'b0, MAX7}) ? MAX7 : sum8[6:0];

    always_comb begin
        state_d = state_q;
        score_d = score;
        round_d = round;
        timer_d = timer_q;
        upd_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    score_d = '0;
                    round_d = '0;
                    timer_d = '0;
                end
            end
            RUN: begin
                if (start) begin
                    score_d = '0;
                    round_d = '0;
                    timer_d = '0;
                end else if (ans_valid || (timer_q == TO_LAST)) begin
                    // An answer on the expiry cycle wins over the timeout.
                    timer_d = '0;
                    upd_d   = 1'b1;
                    to_d    = !ans_valid;
                    if (ans_valid && ans_correct) begin
                        score_d = add_score;
                    end
                    if (round == LAST_ROUND) begin
                        state_d = DONE;
                    end else begin
                        round_d = round + 4'd1;
                    end
                end else begin
                    timer_d = timer_q + TO_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= IDLE;
            score     <= '0;
            round     <= '0;
            timer_q   <= '0;
            score_upd <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            score     <= score_d;
            round     <= round_d;
            timer_q   <= timer_d;
            score_upd <= upd_d;
            timeout   <= to_d;
            busy      <= (state_d == RUN);
            done      <= (state_d == DONE);
        end
    end

endmodule
